// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM byte-serial RAM arbiter: FSM states,
// mem_len codes and common constants.
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_IF_RD  = 3'd1,
        ARB_MEM_RD = 3'd2,
        ARB_MEM_WR = 3'd3,
        ARB_DONE   = 3'd4
    } arb_state_e;

    localparam logic [1:0]  LEN_B     = 2'd0;
    localparam logic [1:0]  LEN_H     = 2'd1;
    localparam logic [1:0]  LEN_W     = 2'd3;

    localparam logic        RstEnable = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // The unused code 2 is serviced as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bundle of the arbiter; slave is the arbiter view,
// master is the pipeline/RAM environment view.
interface mem_arbiter_if #(
    parameter int RAM_AW = 17
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              if_stall_req;
    logic              mem_stall_req;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  ram_din,
        output if_done, if_data, mem_done, mem_rdata,
        output if_stall_req, mem_stall_req,
        output ram_a, ram_wr, ram_dout
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output ram_din,
        input  if_done, if_data, mem_done, mem_rdata,
        input  if_stall_req, mem_stall_req,
        input  ram_a, ram_wr, ram_dout
    );

endinterface

// File: rtl/mem_arbiter_byte_assembler.sv
// Little-endian byte shift-in; word presents the result as if din were the
// final byte, right-aligned and zero-filled above the access length.
module mem_arbiter_byte_assembler
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        shift,
    input  logic [7:0]  din,
    input  logic [1:0]  len,
    output logic [31:0] word
);

    logic [23:0] sr;
    logic [31:0] full;

    assign full = {din, sr};

    always_ff @(posedge clk) begin
        if (shift) begin
            sr <= full[31:8];
        end
    end

    // Older bytes sit below newer ones, so shorter accesses shift down.
    always_comb begin
        word = full;
        case (len)
            LEN_B:   word = {24'h0, full[31:24]};
            LEN_H:   word = {16'h0, full[31:16]};
            default: word = full;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one 8-bit synchronous RAM port between IF and
// MEM. MEM wins ties; an accepted access runs to completion unless IF flushes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    arb_state_e        state, state_n;
    logic [2:0]        step, step_n;
    logic [1:0]        len_q, len_n;
    logic [23:0]       wdata_q, wdata_n;
    logic [RAM_AW-1:0] ram_a, ram_a_n;
    logic              ram_wr, ram_wr_n;
    logic [7:0]        ram_dout, ram_dout_n;
    logic              if_done, if_done_n;
    logic              mem_done, mem_done_n;
    logic [31:0]       if_data, if_data_n;
    logic [31:0]       mem_rdata, mem_rdata_n;
    logic              asm_shift;
    logic [31:0]       asm_word;
    logic [2:0]        nbytes;
    logic              unused_addr_bits;

    assign nbytes           = len_bytes(len_q);
    assign unused_addr_bits = ^{bus.if_addr[31:RAM_AW], bus.mem_addr[31:RAM_AW]};

    mem_arbiter_byte_assembler u_asm (
        .clk   (clk),
        .shift (asm_shift),
        .din   (bus.ram_din),
        .len   (len_q),
        .word  (asm_word)
    );

    // step counts edges since accept; RAM read data lags the address by two edges.
    always_comb begin
        state_n     = state;
        step_n      = step;
        len_n       = len_q;
        wdata_n     = wdata_q;
        ram_a_n     = ram_a;
        ram_wr_n    = 1'b0;
        ram_dout_n  = ram_dout;
        if_done_n   = 1'b0;
        mem_done_n  = 1'b0;
        if_data_n   = if_data;
        mem_rdata_n = mem_rdata;
        asm_shift   = 1'b0;

        case (state)
            ARB_IDLE: begin
                step_n = 3'd0;
                if (bus.mem_req) begin
                    ram_a_n = bus.mem_addr[RAM_AW-1:0];
                    len_n   = bus.mem_len;
                    if (bus.mem_we) begin
                        state_n    = ARB_MEM_WR;
                        ram_wr_n   = 1'b1;
                        ram_dout_n = bus.mem_wdata[7:0];
                        wdata_n    = bus.mem_wdata[31:8];
                    end else begin
                        state_n = ARB_MEM_RD;
                    end
                end else if (bus.if_req && !bus.if_flush) begin
                    state_n = ARB_IF_RD;
                    ram_a_n = bus.if_addr[RAM_AW-1:0];
                    len_n   = LEN_W;
                end
            end

            ARB_IF_RD, ARB_MEM_RD: begin
                if (state == ARB_IF_RD && bus.if_flush) begin
                    state_n = ARB_IDLE;
                end else begin
                    step_n    = step + 3'd1;
                    asm_shift = (step != 3'd0);
                    if (step + 3'd1 < nbytes) begin
                        ram_a_n = ram_a + RAM_AW'(1);
                    end
                    if (step == nbytes) begin
                        state_n = ARB_DONE;
                        if (state == ARB_IF_RD) begin
                            if_done_n = 1'b1;
                            if_data_n = asm_word;
                        end else begin
                            mem_done_n  = 1'b1;
                            mem_rdata_n = asm_word;
                        end
                    end
                end
            end

            ARB_MEM_WR: begin
                step_n = step + 3'd1;
                if (step + 3'd1 == nbytes) begin
                    state_n    = ARB_DONE;
                    mem_done_n = 1'b1;
                end else begin
                    ram_wr_n   = 1'b1;
                    ram_a_n    = ram_a + RAM_AW'(1);
                    ram_dout_n = wdata_q[7:0];
                    wdata_n    = {8'h00, wdata_q[23:8]};
                end
            end

            ARB_DONE: begin
                state_n = ARB_IDLE;
            end

            default: begin
                state_n = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state     <= ARB_IDLE;
            step      <= 3'd0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'h00;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_data   <= ZeroWord;
            mem_rdata <= ZeroWord;
        end else begin
            state     <= state_n;
            step      <= step_n;
            ram_a     <= ram_a_n;
            ram_wr    <= ram_wr_n;
            ram_dout  <= ram_dout_n;
            if_done   <= if_done_n;
            mem_done  <= mem_done_n;
            if_data   <= if_data_n;
            mem_rdata <= mem_rdata_n;
        end
    end

    // Access descriptors are only consumed after an accept reloads them.
    always_ff @(posedge clk) begin
        len_q   <= len_n;
        wdata_q <= wdata_n;
    end

    assign bus.ram_a         = ram_a;
    assign bus.ram_wr        = ram_wr;
    assign bus.ram_dout      = ram_dout;
    assign bus.if_done       = if_done;
    assign bus.if_data       = if_data;
    assign bus.mem_done      = mem_done;
    assign bus.mem_rdata     = mem_rdata;
    assign bus.if_stall_req  = bus.if_req & ~if_done;
    assign bus.mem_stall_req = bus.mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, a transaction-level reference schedule
// checked every cycle, directed scenarios with literal values, then random traffic.
module tb_mem_arbiter;

    localparam int RAM_AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.RAM_AW(RAM_AW)) bus ();

    mem_arbiter #(.RAM_AW(RAM_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, ecount, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // RAM: one-cycle read latency, writes from the arbiter or bench pokes.
    logic [7:0]        ram [0:(1<<RAM_AW)-1];
    logic              filled  = 1'b0;
    logic              poke_en = 1'b0;
    logic [RAM_AW-1:0] poke_a  = '0;
    logic [7:0]        poke_d  = 8'h00;

    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a];
        if (!filled) begin
            for (int i = 0; i < (1 << RAM_AW); i++) ram[i] <= 8'($urandom);
            filled <= 1'b1;
        end else if (poke_en) begin
            ram[poke_a] <= poke_d;
        end else if (bus.ram_wr) begin
            ram[bus.ram_a] <= bus.ram_dout;
        end
    end

    // Reference: expected registered outputs after each edge, from the access schedule.
    logic              x_wr = 1'b0, x_if_done = 1'b0, x_mem_done = 1'b0, x_a_chk = 1'b0;
    logic [RAM_AW-1:0] x_a = '0;
    logic [7:0]        x_dout = 8'h00;
    logic [31:0]       x_if_data = '0, x_mem_rdata = '0;

    initial begin
        bit                active = 0, kind_if = 0, is_wr = 0;
        logic [RAM_AW-1:0] base = '0;
        logic [31:0]       wdata = '0, rdata = '0;
        int                nb = 0, e0 = 0, next_free = 0, t = 0;
        forever begin
            @(posedge clk);
            ecount++;
            x_wr = 0;
            x_if_done = 0;
            x_mem_done = 0;
            if (!rst) begin
                active = 0;
                next_free = ecount + 1;
                x_a = '0;
                x_a_chk = 1;
                x_if_data = '0;
                x_mem_rdata = '0;
            end else begin
                if (active && kind_if && bus.if_flush) begin
                    active = 0;
                    next_free = ecount + 1;
                end else if (!active && ecount >= next_free) begin
                    if (bus.mem_req) begin
                        active = 1; kind_if = 0; is_wr = bus.mem_we;
                        base = bus.mem_addr[RAM_AW-1:0];
                        nb = (bus.mem_len == 2'd0) ? 1 : (bus.mem_len == 2'd1) ? 2 : 4;
                        wdata = bus.mem_wdata;
                    end else if (bus.if_req && !bus.if_flush) begin
                        active = 1; kind_if = 1; is_wr = 0;
                        base = bus.if_addr[RAM_AW-1:0];
                        nb = 4;
                    end
                    if (active) begin
                        e0 = ecount;
                        rdata = '0;
                        for (int k = 0; k < nb; k++)
                            rdata = rdata | (32'(ram[base + RAM_AW'(k)]) << (8 * k));
                    end
                end
                if (active) begin
                    t = ecount - e0;
                    if (t < nb) begin
                        x_a = base + RAM_AW'(t);
                        x_a_chk = 1;
                        if (is_wr) begin
                            x_wr = 1;
                            x_dout = wdata[8*t +: 8];
                        end
                    end
                    if (is_wr && t == nb) begin
                        x_mem_done = 1;
                        x_a_chk = 0;
                        active = 0;
                        next_free = ecount + 2;
                    end else if (!is_wr && t == nb + 1) begin
                        if (kind_if) begin
                            x_if_done = 1;
                            x_if_data = rdata;
                        end else begin
                            x_mem_done = 1;
                            x_mem_rdata = rdata;
                        end
                        active = 0;
                        next_free = ecount + 2;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (ecount > 0) begin
                check("ram_wr", 32'(bus.ram_wr), 32'(x_wr));
                check("if_done", 32'(bus.if_done), 32'(x_if_done));
                check("mem_done", 32'(bus.mem_done), 32'(x_mem_done));
                check("if_data", bus.if_data, x_if_data);
                check("mem_rdata", bus.mem_rdata, x_mem_rdata);
                if (x_a_chk) check("ram_a", 32'(bus.ram_a), 32'(x_a));
                if (x_wr) check("ram_dout", 32'(bus.ram_dout), 32'(x_dout));
                check("if_stall_req", 32'(bus.if_stall_req), 32'(bus.if_req & ~x_if_done));
                check("mem_stall_req", 32'(bus.mem_stall_req), 32'(bus.mem_req & ~x_mem_done));
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 511));
            1:       return {$urandom_range(0, 32767), 17'h1FFF0} + 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [RAM_AW-1:0] pa [14];
        logic [7:0]        pd [14];
        logic [7:0]        sb [4];
        logic [RAM_AW-1:0] wrap_a [4];
        int                cnt;
        bit                seen;

        pa = '{17'h100, 17'h101, 17'h102, 17'h103, 17'h20, 17'h21, 17'h200,
               17'h201, 17'h202, 17'h203, 17'h1FFFE, 17'h1FFFF, 17'h0, 17'h1};
        pd = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'h11,
               8'h22, 8'h33, 8'h44, 8'h01, 8'h02, 8'h03, 8'h04};
        sb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wrap_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};

        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.if_flush = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_len = 2'd0;
        bus.mem_addr = '0; bus.mem_wdata = '0;

        // Reset held two cycles with a pending IF request.
        edge1();
        edge1();
        check("reset ram_wr", 32'(bus.ram_wr), 32'h0);
        check("reset ram_a", 32'(bus.ram_a), 32'h0);
        check("reset if_done", 32'(bus.if_done), 32'h0);
        check("reset mem_done", 32'(bus.mem_done), 32'h0);
        check("reset if_data", bus.if_data, 32'h0);
        check("reset mem_rdata", bus.mem_rdata, 32'h0);
        rst = 1'b1;
        bus.if_req = 1'b0;

        for (int i = 0; i < 14; i++) begin
            poke_a = pa[i]; poke_d = pd[i]; poke_en = 1'b1;
            edge1();
        end
        poke_en = 1'b0;

        // IF word read at 0x100.
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int k = 0; k < 6; k++) begin
            edge1();
            if (k < 4) check("if_rd ram_a", 32'(bus.ram_a), 32'h100 + 32'(k));
            check("if_rd done timing", 32'(bus.if_done), (k == 5) ? 32'h1 : 32'h0);
        end
        check("if_rd if_data", bus.if_data, 32'h0000_0513);
        bus.if_req = 1'b0;
        edge1();
        check("if_rd done pulse width", 32'(bus.if_done), 32'h0);

        // IF and MEM together: MEM halfword load first, IF after the done cycle.
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd1; bus.mem_addr = 32'h20;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        for (int k = 0; k < 4; k++) edge1();
        check("conflict mem_done", 32'(bus.mem_done), 32'h1);
        check("conflict mem_rdata", bus.mem_rdata, 32'h0000_BBAA);
        check("conflict if_done", 32'(bus.if_done), 32'h0);
        bus.mem_req = 1'b0;
        edge1();
        check("conflict done cycle", 32'(bus.mem_done), 32'h0);
        edge1();
        check("conflict if accept ram_a", 32'(bus.ram_a), 32'h100);
        for (int k = 0; k < 5; k++) edge1();
        check("conflict if_done", 32'(bus.if_done), 32'h1);
        check("conflict if_data", bus.if_data, 32'h0000_0513);
        bus.if_req = 1'b0;
        edge1();

        // Word store at 0x40.
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd3;
        bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            edge1();
            check("store ram_wr", 32'(bus.ram_wr), 32'h1);
            check("store ram_a", 32'(bus.ram_a), 32'h40 + 32'(k));
            check("store ram_dout", 32'(bus.ram_dout), 32'(sb[k]));
        end
        edge1();
        check("store ram_wr end", 32'(bus.ram_wr), 32'h0);
        check("store mem_done", 32'(bus.mem_done), 32'h1);
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        edge1();
        check("store ram contents", {ram[17'h43], ram[17'h42], ram[17'h41], ram[17'h40]}, 32'hDEAD_BEEF);

        // Flush during IF read, then a fresh fetch at 0x200.
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        edge1();
        edge1();
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        edge1();
        check("flush if_done", 32'(bus.if_done), 32'h0);
        check("flush if_data kept", bus.if_data, 32'h0000_0513);
        bus.if_flush = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h200;
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            edge1();
            cnt++;
            if (bus.if_done) seen = 1;
        end
        check("refetch done seen", 32'(seen), 32'h1);
        check("refetch latency edges", 32'(cnt), 32'd6);
        check("refetch if_data", bus.if_data, 32'h4433_2211);
        bus.if_req = 1'b0;
        edge1();

        // Word load crossing the top of the RAM address space.
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd3; bus.mem_addr = 32'h0003_FFFE;
        for (int k = 0; k < 4; k++) begin
            edge1();
            check("wrap ram_a", 32'(bus.ram_a), 32'(wrap_a[k]));
        end
        edge1();
        edge1();
        check("wrap mem_done", 32'(bus.mem_done), 32'h1);
        check("wrap mem_rdata", bus.mem_rdata, 32'h0403_0201);
        bus.mem_req = 1'b0;
        edge1();

        // Random traffic including flushes, dropped requests and resets.
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 299) != 0);
            bus.if_req    = ($urandom_range(0, 2) == 0);
            bus.if_addr   = rand_addr();
            bus.if_flush  = ($urandom_range(0, 7) == 0);
            bus.mem_req   = ($urandom_range(0, 2) == 0);
            bus.mem_we    = $urandom_range(0, 1) == 1;
            bus.mem_len   = 2'($urandom_range(0, 3));
            bus.mem_addr  = rand_addr();
            bus.mem_wdata = $urandom();
            edge1();
        end

        rst = 1'b1;
        bus.if_req = 1'b0; bus.mem_req = 1'b0; bus.if_flush = 1'b0;
        repeat (10) edge1();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide synchronous RAM port between the instruction-fetch stage (IF) and the load/store stage (MEM).
- Serialises each multi-byte access into byte transactions and assembles read data little-endian.
- Pulses a one-cycle done to the requester when the access completes.
- Drives stall requests so the pipeline controller can freeze the stages while an access is outstanding.

Parameters:
RAM_AW, 17, width of the RAM byte address bus; request addresses are truncated to this width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active low (rst==0 resets)
if_req  in  1  IF requests a 4-byte instruction read
if_addr  in  32  IF byte address
if_flush  in  1  abort an in-flight IF read (branch redirect)
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  assembled instruction word
mem_req  in  1  MEM requests an access
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  bytes minus one: 0 = 1B, 1 = 2B, 3 = 4B (2 is illegal and treated as 4B)
mem_addr  in  32  MEM byte address
mem_wdata  in  32  store data; byte i = bits [8i+7:8i]
mem_done  out  1  one-cycle pulse: access complete
mem_rdata  out  32  load data, zero-filled above mem_len
if_stall_req  out  1  if_req & ~if_done
mem_stall_req  out  1  mem_req & ~mem_done
ram_a  out  RAM_AW  RAM byte address
ram_wr  out  1  RAM write enable
ram_dout  out  8  byte to RAM
ram_din  in  8  byte from RAM; holds byte[A] in the cycle after the edge at which the RAM sampled A

Behaviour:
- Reset (rst low at posedge): state IDLE, counters 0. Outputs: ram_a=0, ram_wr=0, ram_dout=0, if_done=0, mem_done=0, if_data=0, mem_rdata=0.
- All outputs are registered except the two stall_req outputs.
- States:
  - IDLE: at the edge, if mem_req: latch addr/len/we/wdata, go MEM_RD or MEM_WR. Else if if_req: latch if_addr, go IF_RD. Else stay.
  - Priority: MEM over IF when both are high in IDLE.
  - Once an access is accepted it is never pre-empted.
- Read of N bytes (IF_RD, MEM_RD), accept edge E0:
  - ram_a = A+k is set at edge Ek for k = 0..N-1; ram_wr = 0.
  - Byte k is captured from ram_din at edge E(k+2).
  - At edge E(N+1): done=1, data output updated, go DONE.
  - Latency: 4-byte read = 5 edges after accept.
- Write of N bytes (MEM_WR):
  - At edge Ek (k = 0..N-1): ram_a = A+k, ram_wr = 1, ram_dout = byte k.
  - At edge EN: ram_wr = 0, mem_done = 1, go DONE.
- DONE: lasts exactly one cycle with done high; requests are ignored. Next edge: done = 0, return IDLE. The requester must drop or change req by then.
- Address arithmetic: A+k is mod 2^RAM_AW; wrap from all-ones to 0 is allowed, with no fault.
- if_flush:
  - In IF_RD: next edge returns to IDLE, ram_a unchanged, ram_wr = 0, no if_done, if_data unchanged.
  - In IDLE with if_req: the request is not accepted that edge.
  - Ignored in MEM_* and DONE.
- mem_rdata upper bytes beyond N are 0; sign extension is done in the MEM stage.
- Reset mid-access (rst low in any state): immediate return to IDLE with reset outputs. A partial write may leave earlier bytes written; this is acceptable.
- Requests dropped mid-access are ignored; the access completes.

Decomposition:
- Shared define header holds:
  - state encodings ARB_IDLE, ARB_IF_RD, ARB_MEM_RD, ARB_MEM_WR, ARB_DONE
  - mem_len codes LEN_B, LEN_H, LEN_W
  - the existing RstEnable / ZeroWord constants
- One natural sub-module, byte_assembler: shift-in of captured bytes into a 32-bit word with zero-fill by length. Reused for IF and MEM reads.

Test Plan:
- Reset: rst low 2 cycles with if_req=1 -> all outputs 0, ram_wr never 1, no done.
- IF read: if_addr=0x100, RAM[0x100..0x103] = 13 05 00 00, accept at E0 -> ram_a 0x100..0x103 on E0..E3, if_done single pulse after E5, if_data = 0x00000513.
- Conflict: if_req and mem_req (load, len=1, addr 0x20, RAM = AA BB) high together in IDLE -> MEM served first, mem_rdata = 0x0000BBAA after E3, DONE cycle, then IF accepted next IDLE edge.
- Store word: mem_we=1, addr 0x40, wdata 0xDEADBEEF -> ram_wr=1 with (0x40,EF), (0x41,BE), (0x42,AD), (0x43,DE) on consecutive cycles, mem_done pulse after E4, ram_wr=0.
- Flush: if_flush high during IF_RD cycle 2 -> IDLE next edge, no if_done, if_data unchanged; a fresh if_req at 0x200 then completes normally.
- Wrap: RAM_AW=17, load len=3 at 0x1FFFE -> ram_a 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 in order.
